reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  32-entry architectural register file of the single-cycle core, directly upstream of the ALU.
//  - Provides two combinational read ports: rs1_data drives ALU operand a, rs2_data drives operand b.
//  - Provides one synchronous write port for the writeback result.
//  - After reset, a clear sequencer zeroes the array one entry per cycle, then raises ready.
//  - Register 0 is hardwired to zero.
// PARAMETERS
//  XLEN      32  data width; matches the ALU operand width
//  NUM_REGS  32  number of architectural registers (power of two, >= 2)
//  ADDR_W    5   register index width, = log2(NUM_REGS)
// PORTS
//  clk       in   1       core clock; all state updates on the rising edge
//  rst       in   1       synchronous, active-high reset
//  rs1_addr  in   ADDR_W  read port 1 index
//  rs2_addr  in   ADDR_W  read port 2 index
//  rs1_data  out  XLEN    read port 1 data, to ALU input a
//  rs2_data  out  XLEN    read port 2 data, to ALU input b
//  reg_write in   1       write enable from control
//  rd_addr   in   ADDR_W  write index
//  rd_data   in   XLEN    write data (ALU or memory result)
//  ready     out  1       1 = clear done, file usable; 0 = clearing
// BEHAVIOUR
//  FSM states: CLEAR and RUN.
//  - rst=1 at a clock edge:
//    - state <= CLEAR, clr_cnt <= 1, ready <= 0.
//    - Takes priority over everything, including a reset that arrives mid-clear or mid-run.
//  - CLEAR, each edge:
//    - mem[clr_cnt] <= 0; clr_cnt <= clr_cnt+1.
//    - When clr_cnt == NUM_REGS-1: write that entry, then state <= RUN and ready <= 1.
//    - Clear therefore takes NUM_REGS-1 edges after rst deasserts. ready is 1 from the next cycle on.
//  - CLEAR behaviour of the ports:
//    - reg_write is ignored: no array write and no bypass.
//    - rs1_data and rs2_data are forced to 0.
//  - RUN write: at the edge, if reg_write && rd_addr != 0, then mem[rd_addr] <= rd_data.
//    - Writes to index 0 are dropped.
//  - RUN read: combinational, zero cycles of latency.
//    - rsN_addr == 0 gives rsN_data = 0.
//    - Otherwise, if reg_write && rd_addr == rsN_addr, rsN_data = rd_data (write-first bypass).
//    - Otherwise, rsN_data = mem[rsN_addr].
//    - Both ports may read the same index, including the index being written; both get the bypassed value.
//  - Reset values: ready = 0, state = CLEAR, clr_cnt = 1.
//    - rs1_data and rs2_data are 0 during reset and during CLEAR.
//    - Array contents are undefined until the clear completes.
//  - No arithmetic on data. clr_cnt is ADDR_W bits and never wraps, because it stops at NUM_REGS-1.
// STRUCTURE
//  - Shared package cpu_pkg holds:
//    - XLEN and REG_ADDR_W localparams
//    - regfile_state_t enum {CLEAR, RUN}
//    - ZERO_REG constant (index 0)
//  - One sub-module, reg_file_clear_seq. It owns the FSM and clr_cnt, and outputs clr_en, clr_idx and ready.
//  - The array, write mux and read/bypass logic stay in reg_file.
// TESTING
//  1. Pulse rst for 1 cycle, then idle.
//     -> ready=0 for exactly 31 edges, then 1.
//     -> Every index reads 0 afterwards.
//  2. Write rd_addr=5, rd_data=32'hDEADBEEF, with reg_write=1 for 1 cycle.
//     -> Next cycle, rs1_addr=5 reads 32'hDEADBEEF and rs2_addr=5 reads the same value.
//  3. Write rd_addr=0, rd_data=32'h12345678.
//     -> rs1_addr=0 reads 0 in the same cycle and in every later cycle.
//  4. In the same cycle: reg_write=1, rd_addr=7, rd_data=100, rs1_addr=7, rs2_addr=7.
//     -> rs1_data=rs2_data=100 combinationally.
//     -> An ALU add of the two yields 200.
//  5. During CLEAR, drive reg_write=1, rd_addr=3, rd_data=55.
//     -> rs1_addr=3 reads 0; after ready, index 3 still reads 0.
//  6. After RUN, write index 9 = 77, then assert rst mid-run for 1 cycle.
//     -> ready drops the next cycle.
//     -> After 31 clear edges, index 9 reads 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the core's register file.
//   XLEN            datapath width, shared with the ALU operands
//   REG_ADDR_W      architectural register index width
//   regfile_state_t clear sequencer states
//   ZERO_REG        index of the hardwired-zero register
package cpu_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } regfile_state_t;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer for the register file.
// Walks indices 1..NUM_REGS-1 one per cycle (index 0 is hardwired and never
// stored), then enters RUN and raises ready.
//   clk      core clock
//   rst      synchronous active-high reset
//   clr_en   1 = write zero to clr_idx at this edge
//   clr_idx  entry being cleared this cycle
//   ready    registered, 1 once the clear has completed
module reg_file_clear_seq
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_idx,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   regfile_state_t    state;
   logic [ADDR_W-1:0] clr_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= ADDR_W'(1);
         ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               // Counter holds at the last index so it can never wrap.
               if (clr_cnt == LAST_IDX) begin
                  state <= RUN;
                  ready <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + ADDR_W'(1);
               end
            end
            RUN: begin
               state <= RUN;
            end
            default: begin
               state   <= CLEAR;
               clr_cnt <= ADDR_W'(1);
               ready   <= 1'b0;
            end
         endcase
      end
   end

   // Reset wins over the clear write at the same edge.
   assign clr_en  = (state == CLEAR) && !rst;
   assign clr_idx = clr_cnt;

endmodule

// File: rtl/reg_file.sv
// 32-entry architectural register file feeding the ALU.
//   clk       core clock
//   rst       synchronous active-high reset (starts the clear sequence)
//   rs1_addr  read port 1 index -> rs1_data (ALU operand a)
//   rs2_addr  read port 2 index -> rs2_data (ALU operand b)
//   reg_write write enable from control
//   rd_addr   write index
//   rd_data   write data (ALU or memory result)
//   ready     1 = clear done, file usable
// Reads are combinational with write-first bypass; register 0 reads zero.
module reg_file
   import cpu_pkg::*;
#(
   parameter int XLEN     = cpu_pkg::XLEN,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = cpu_pkg::REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]   rs1_data,
   output logic [XLEN-1:0]   rs2_data,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [XLEN-1:0]   rd_data,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   logic [XLEN-1:0]   mem [NUM_REGS];
   logic              clr_en;
   logic [ADDR_W-1:0] clr_idx;
   logic              run_ok;
   logic              run_we;

   reg_file_clear_seq #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_clear_seq (
      .clk     (clk),
      .rst     (rst),
      .clr_en  (clr_en),
      .clr_idx (clr_idx),
      .ready   (ready)
   );

   // The file only behaves as a register file in RUN with no reset pending;
   // otherwise writes are dropped and both read ports return zero.
   assign run_ok = ready && !rst;
   assign run_we = run_ok && reg_write && (rd_addr != ZERO_IDX);

   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_idx] <= '0;
      end else if (run_we) begin
         mem[rd_addr] <= rd_data;
      end
   end

   function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] addr);
      if (!run_ok || addr == ZERO_IDX) begin
         return '0;
      end else if (reg_write && rd_addr == addr) begin
         return rd_data;
      end else begin
         return mem[addr];
      end
   endfunction

   always_comb begin
      rs1_data = read_port(rs1_addr);
      rs2_data = read_port(rs2_addr);
   end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: clear timing, directed vector table,
// randomized traffic against an array model, and reset corner cases.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [31:0] rs1_data, rs2_data, rd_data;
   logic        reg_write;
   logic        ready;

   int tests  = 0;
   int failed = 0;

   logic [31:0] model [32];

   reg_file dut (
      .clk       (clk),
      .rst       (rst),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .reg_write (reg_write),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference read: zero register, then same-cycle write, then stored value.
   function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] rd, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if (we && rd == a) return wd;
      return model[a];
   endfunction

   task automatic model_write(input logic we, input logic [4:0] rd, input logic [31:0] wd);
      if (we && rd != 5'd0) model[rd] = wd;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   // Counts edges after the reset edge until ready rises (bounded).
   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic sweep_zero(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         if (rs1_data !== 32'd0 || rs2_data !== 32'd0) bad++;
      end
      check(name, 32'(bad), 32'd0);
   endtask

   initial begin
      int n;
      int clr_bad;
      logic        we;
      logic [4:0]  rd, a1, a2;
      logic [31:0] wd;

      rst = 1'b1; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
      rs1_addr = 5'd3; rs2_addr = 5'd3;

      // Reset pulse, with a write to index 3 held during the whole clear.
      tick();
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_rs1", rs1_data, 32'd0);
      rst = 1'b0;
      reg_write = 1'b1; rd_addr = 5'd3; rd_data = 32'd55;
      n = 0; clr_bad = 0;
      while (!ready && n < 100) begin
         #1;
         if (rs1_data !== 32'd0 || rs2_data !== 32'd0) clr_bad++;
         tick();
         n++;
      end
      reg_write = 1'b0;
      check("clear_edges", 32'(n), 32'd31);
      check("clear_reads_zero", 32'(clr_bad), 32'd0);
      rs1_addr = 5'd3;
      #1;
      check("idx3_after_clear", rs1_data, 32'd0);
      sweep_zero("all_zero_after_clear");
      model_clear();

      // Directed vectors, each checked combinationally before its write edge.
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
      vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
      vecs[4] = '{1'b1, 5'd7,  32'd100,      5'd7,  5'd7,  32'd100,      32'd100};
      vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'd100,      32'hDEADBEEF};
      vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
      vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  32'hFFFFFFFF, 32'h0};
      vecs[8] = '{1'b1, 5'd5,  32'h1,        5'd5,  5'd5,  32'h1,        32'h1};
      vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'h1,        32'd100};
      for (int i = 0; i < 10; i++) begin
         reg_write = vecs[i].we; rd_addr = vecs[i].rd; rd_data = vecs[i].wd;
         rs1_addr = vecs[i].a1;  rs2_addr = vecs[i].a2;
         #1;
         check($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
         check($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
         if (i == 4) check("alu_add", rs1_data + rs2_data, 32'd200);
         tick();
         model_write(vecs[i].we, vecs[i].rd, vecs[i].wd);
      end
      reg_write = 1'b0;
      rs1_addr = 5'd0;
      #1;
      check("zero_stays_zero", rs1_data, 32'd0);

      // Randomized traffic against the array model.
      for (int i = 0; i < 400; i++) begin
         we = 1'($urandom_range(0, 1));
         rd = 5'($urandom_range(0, 31));
         wd = $urandom;
         a1 = (i % 4 == 0) ? rd : 5'($urandom_range(0, 31));
         a2 = (i % 5 == 0) ? rd : 5'($urandom_range(0, 31));
         reg_write = we; rd_addr = rd; rd_data = wd;
         rs1_addr = a1; rs2_addr = a2;
         #1;
         check("rand_rs1", rs1_data, ref_read(a1, we, rd, wd));
         check("rand_rs2", rs2_data, ref_read(a2, we, rd, wd));
         tick();
         model_write(we, rd, wd);
      end

      // Mid-run reset wipes a written entry.
      reg_write = 1'b1; rd_addr = 5'd9; rd_data = 32'd77;
      tick();
      reg_write = 1'b0; rs1_addr = 5'd9; rs2_addr = 5'd9;
      #1;
      check("idx9_written", rs1_data, 32'd77);
      rst = 1'b1;
      #1;
      check("rs1_zero_in_reset", rs1_data, 32'd0);
      tick();
      rst = 1'b0;
      check("ready_drops", {31'd0, ready}, 32'd0);
      wait_ready(n);
      check("midrun_clear_edges", 32'(n), 32'd31);
      rs1_addr = 5'd9;
      #1;
      check("idx9_cleared", rs1_data, 32'd0);

      // Reset arriving mid-clear restarts the full sequence.
      reg_write = 1'b1; rd_addr = 5'd12; rd_data = 32'd5;
      tick();
      reg_write = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(n);
      check("midclear_restart_edges", 32'(n), 32'd31);
      sweep_zero("all_zero_after_restart");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
